// File: rtl/fp_result_scoreboard.sv
// In-order expected-result scoreboard for the FPU: FIFO of expected entries popped on each dut_ready.
// Optional watchdog enabled by defining FP_SCB_TIMEOUT_EN.
module fp_result_scoreboard #(
  parameter int unsigned FLEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [FLEN-1:0]          push_result,
  input  logic [4:0]               push_flags,
  input  logic [9:0]               push_opcode,
  input  logic                     dut_ready,
  input  logic [FLEN-1:0]          dut_result,
  input  logic [4:0]               dut_flags,
  input  logic                     stop,
  output logic [31:0]              pass_count,
  output logic                     fail,
  output logic [1:0]               fail_cause,
  output logic [FLEN-1:0]          fail_exp_result,
  output logic [FLEN-1:0]          fail_got_result,
  output logic [4:0]               fail_exp_flags,
  output logic [4:0]               fail_got_flags,
  output logic [9:0]               fail_opcode,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [63:0] QNAN64 = (FLEN == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
  // Exponent plus quiet bit: bits [62:51] for double, [30:22] for single.
  localparam logic [63:0] MASK64 = (FLEN == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
  localparam logic [FLEN-1:0] QNAN     = QNAN64[FLEN-1:0];
  localparam logic [FLEN-1:0] NAN_MASK = MASK64[FLEN-1:0];

  if (FLEN != 32 && FLEN != 64) begin : g_bad_flen
    $error("fp_result_scoreboard: FLEN must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_result_scoreboard: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("fp_result_scoreboard: TIMEOUT must fit the 16-bit watchdog");
  end

  typedef enum logic [1:0] { S_RUN, S_FAIL, S_DONE } state_t;
  typedef enum logic [1:0] { C_NONE, C_MISMATCH, C_UNDERFLOW, C_TIMEOUT } cause_t;

  state_t state_q, state_d;
  cause_t cause_q;

  logic [FLEN-1:0] mem_result [DEPTH];
  logic [4:0]      mem_flags  [DEPTH];
  logic [9:0]      mem_opcode [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  logic            in_run, do_push, do_pop, underflow, mismatch, timeout_hit, any_fail;
  logic [FLEN-1:0] head_result;
  logic [4:0]      head_flags;
  logic [9:0]      head_opcode;
  logic            nan_masked, result_ok, match;

  assign in_run      = (state_q == S_RUN);
  assign push_ready  = (occupancy < OCC_FULL) || dut_ready;
  assign do_push     = in_run && push_valid && push_ready;
  assign do_pop      = in_run && dut_ready && (occupancy != '0);
  assign underflow   = in_run && dut_ready && (occupancy == '0);

  assign head_result = mem_result[rd_ptr];
  assign head_flags  = mem_flags[rd_ptr];
  assign head_opcode = mem_opcode[rd_ptr];

  // Conversions and compares produce integer bit patterns, so NaN payload masking never applies there.
  assign nan_masked  = !head_opcode[9] && !head_opcode[6] && (dut_result == QNAN);
  assign result_ok   = nan_masked ? (((head_result ^ dut_result) & NAN_MASK) == '0)
                                  : (head_result == dut_result);
  assign match       = result_ok && (head_flags == dut_flags);
  assign mismatch    = do_pop && !match;

`ifdef FP_SCB_TIMEOUT_EN
  logic [15:0] watchdog;
  logic        wd_counting;

  assign wd_counting = in_run && (occupancy != '0) && !dut_ready;
  assign timeout_hit = wd_counting && (watchdog == 16'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      watchdog <= '0;
    end else if (wd_counting) begin
      watchdog <= watchdog + 16'd1;
    end else begin
      watchdog <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign any_fail = underflow || mismatch || timeout_hit;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Occupancy is sampled before this cycle's pop, so a matching final pop reaches DONE one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (any_fail)                          state_d = S_FAIL;
        else if (stop && (occupancy == '0))    state_d = S_DONE;
      end
      S_FAIL:  state_d = S_FAIL;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  assign fail       = (state_q == S_FAIL);
  assign done       = (state_q == S_DONE);
  assign fail_cause = cause_q;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_result[wr_ptr] <= push_result;
      mem_flags[wr_ptr]  <= push_flags;
      mem_opcode[wr_ptr] <= push_opcode;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      occupancy <= occupancy + 1'b1;
      else if (do_pop && !do_push) occupancy <= occupancy - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pass_count      <= '0;
      cause_q         <= C_NONE;
      fail_exp_result <= '0;
      fail_got_result <= '0;
      fail_exp_flags  <= '0;
      fail_got_flags  <= '0;
      fail_opcode     <= '0;
    end else if (in_run) begin
      if (underflow) begin
        cause_q         <= C_UNDERFLOW;
        fail_exp_result <= '0;
        fail_exp_flags  <= '0;
        fail_opcode     <= '0;
        fail_got_result <= dut_result;
        fail_got_flags  <= dut_flags;
      end else if (mismatch) begin
        cause_q         <= C_MISMATCH;
        fail_exp_result <= head_result;
        fail_exp_flags  <= head_flags;
        fail_opcode     <= head_opcode;
        fail_got_result <= dut_result;
        fail_got_flags  <= dut_flags;
      end else if (timeout_hit) begin
        cause_q         <= C_TIMEOUT;
        fail_exp_result <= head_result;
        fail_exp_flags  <= head_flags;
        fail_opcode     <= head_opcode;
        fail_got_result <= '0;
        fail_got_flags  <= '0;
      end else if (do_pop && (pass_count != '1)) begin
        pass_count <= pass_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fp_result_scoreboard.sv
// Directed self-checking bench for fp_result_scoreboard (FLEN=32, DEPTH=8, TIMEOUT=64).
module tb_fp_result_scoreboard;

  logic        clock;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_result;
  logic [4:0]  push_flags;
  logic [9:0]  push_opcode;
  logic        dut_ready;
  logic [31:0] dut_result;
  logic [4:0]  dut_flags;
  logic        stop;
  logic [31:0] pass_count;
  logic        fail;
  logic [1:0]  fail_cause;
  logic [31:0] fail_exp_result;
  logic [31:0] fail_got_result;
  logic [4:0]  fail_exp_flags;
  logic [4:0]  fail_got_flags;
  logic [9:0]  fail_opcode;
  logic        done;
  logic [3:0]  occupancy;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  fp_result_scoreboard #(.FLEN(32), .DEPTH(8), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_result(push_result), .push_flags(push_flags), .push_opcode(push_opcode),
    .dut_ready(dut_ready), .dut_result(dut_result), .dut_flags(dut_flags),
    .stop(stop), .pass_count(pass_count), .fail(fail), .fail_cause(fail_cause),
    .fail_exp_result(fail_exp_result), .fail_got_result(fail_got_result),
    .fail_exp_flags(fail_exp_flags), .fail_got_flags(fail_got_flags),
    .fail_opcode(fail_opcode), .done(done), .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    push_valid = 1'b0;
    dut_ready  = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    push_valid = 1'b0; push_result = '0; push_flags = '0; push_opcode = '0;
    dut_ready  = 1'b0; dut_result  = '0; dut_flags  = '0; stop = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic set_push(input logic [31:0] r, input logic [4:0] f, input logic [9:0] o);
    push_valid = 1'b1; push_result = r; push_flags = f; push_opcode = o;
  endtask

  task automatic set_pop(input logic [31:0] r, input logic [4:0] f);
    dut_ready = 1'b1; dut_result = r; dut_flags = f;
  endtask

  task automatic push(input logic [31:0] r, input logic [4:0] f, input logic [9:0] o);
    set_push(r, f, o);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic pop(input logic [31:0] r, input logic [4:0] f);
    set_pop(r, f);
    tick();
    dut_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    do_reset();

    // Reset state
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_occupancy",  64'(occupancy),  64'd0);
    chk("rst_pass_count", 64'(pass_count), 64'd0);
    chk("rst_fail",       64'(fail),       64'd0);
    chk("rst_done",       64'(done),       64'd0);
    chk("rst_cause",      64'(fail_cause), 64'd0);
    chk("rst_exp_result", 64'(fail_exp_result), 64'd0);

    // Three entries, in-order return with varied latency
    push(32'h3F80_0000, 5'h00, 10'h001);
    set_push(32'h4000_0000, 5'h00, 10'h001);
    set_pop(32'h3F80_0000, 5'h00);
    tick();
    dut_ready = 1'b0;
    push(32'h4040_0000, 5'h00, 10'h001);
    chk("inord_occ_mid",  64'(occupancy),  64'd2);
    chk("inord_pass_mid", 64'(pass_count), 64'd1);
    idle();
    idle();
    pop(32'h4000_0000, 5'h00);
    idle();
    stop = 1'b1;
    pop(32'h4040_0000, 5'h00);
    chk("inord_pass3",      64'(pass_count), 64'd3);
    chk("inord_done_late",  64'(done),       64'd0);
    chk("inord_occ0",       64'(occupancy),  64'd0);
    tick();
    chk("inord_done",       64'(done),       64'd1);
    chk("inord_fail",       64'(fail),       64'd0);
    // Pushes ignored once DONE
    push(32'h1111_1111, 5'h00, 10'h001);
    chk("done_push_ignored", 64'(occupancy), 64'd0);

    // Masked canonical-NaN compare
    do_reset();
    chk("reset_clears_done", 64'(done), 64'd0);
    push(32'h7FC0_0001, 5'h10, 10'h002);
    pop(32'h7FC0_0000, 5'h10);
    chk("nan_mask_pass", 64'(pass_count), 64'd1);
    chk("nan_mask_fail", 64'(fail),       64'd0);

    // fcvt_f2i: full compare, mismatch captured
    do_reset();
    push(32'h7FC0_0001, 5'h00, 10'h200);
    pop(32'h7FC0_0000, 5'h00);
    chk("f2i_fail",    64'(fail),            64'd1);
    chk("f2i_cause",   64'(fail_cause),      64'd1);
    chk("f2i_exp",     64'(fail_exp_result), 64'h7FC0_0001);
    chk("f2i_got",     64'(fail_got_result), 64'h7FC0_0000);
    chk("f2i_opcode",  64'(fail_opcode),     64'h200);
    chk("f2i_pass",    64'(pass_count),      64'd0);

    // Flag-only mismatch
    do_reset();
    push(32'h4000_0000, 5'h01, 10'h001);
    pop(32'h4000_0000, 5'h00);
    chk("flag_cause",    64'(fail_cause),     64'd1);
    chk("flag_exp_flg",  64'(fail_exp_flags), 64'h01);
    chk("flag_got_flg",  64'(fail_got_flags), 64'h00);

    // Full FIFO, dropped push, simultaneous push/pop when full
    do_reset();
    for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i), 5'h00, 10'h001);
    chk("full_occ",        64'(occupancy),  64'd8);
    chk("full_ready",      64'(push_ready), 64'd0);
    push(32'h0000_DEAD, 5'h00, 10'h001);
    chk("full_drop_occ",   64'(occupancy),  64'd8);
    set_push(32'h1008, 5'h00, 10'h001);
    set_pop(32'h1000, 5'h00);
    #1;
    chk("full_ready_pop",  64'(push_ready), 64'd1);
    tick();
    push_valid = 1'b0;
    dut_ready  = 1'b0;
    chk("full_pp_occ",     64'(occupancy),  64'd8);
    chk("full_pp_pass",    64'(pass_count), 64'd1);
    for (int i = 1; i <= 8; i++) pop(32'h1000 + 32'(i), 5'h00);
    chk("drain_pass",      64'(pass_count), 64'd9);
    chk("drain_occ",       64'(occupancy),  64'd0);
    chk("drain_fail",      64'(fail),       64'd0);

    // Underflow: a same-cycle push is not visible to the pop
    do_reset();
    set_push(32'h1234, 5'h03, 10'h004);
    set_pop(32'h1234, 5'h03);
    tick();
    push_valid = 1'b0;
    dut_ready  = 1'b0;
    chk("uf_fail",      64'(fail),            64'd1);
    chk("uf_cause",     64'(fail_cause),      64'd2);
    chk("uf_got",       64'(fail_got_result), 64'h1234);
    chk("uf_got_flags", 64'(fail_got_flags),  64'h03);
    chk("uf_exp",       64'(fail_exp_result), 64'd0);
    chk("uf_opcode",    64'(fail_opcode),     64'd0);
    pop(32'h5555, 5'h1F);
    chk("uf_frozen_got",  64'(fail_got_result), 64'h1234);
    chk("uf_frozen_pass", 64'(pass_count),      64'd0);
    chk("uf_frozen_cause",64'(fail_cause),      64'd2);

    // Watchdog
    do_reset();
    push(32'h3F80_0000, 5'h02, 10'h004);
`ifdef FP_SCB_TIMEOUT_EN
    for (int i = 0; i < 63; i++) tick();
    chk("wd_not_yet",  64'(fail),            64'd0);
    tick();
    chk("wd_fail",     64'(fail),            64'd1);
    chk("wd_cause",    64'(fail_cause),      64'd3);
    chk("wd_exp",      64'(fail_exp_result), 64'h3F80_0000);
    chk("wd_exp_flg",  64'(fail_exp_flags),  64'h02);
    chk("wd_got",      64'(fail_got_result), 64'd0);
    chk("wd_opcode",   64'(fail_opcode),     64'h004);
`else
    for (int i = 0; i < 1000; i++) tick();
    chk("nowd_fail",   64'(fail),      64'd0);
    chk("nowd_occ",    64'(occupancy), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
